ball_flight_ctrl: RTL and testbench

//  Receiving end of the cannon launch handshake. Consumes the startGame pulse and 3-bit startSpeed

---
 rtl/ball_pkg.sv | 44 ++++
 rtl/ball_flight_ctrl_if.sv | 21 ++
 rtl/ball_speed_lut.sv | 14 +
 rtl/ball_flight_ctrl.sv | 135 +++++++++++++
 tb/tb_ball_flight_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/ball_pkg.sv
// ball_pkg: constants, state codes and velocity helpers shared by the ball
// flight controller, the launch FSM and the ball drawer.
package ball_pkg;
  localparam int HOME_X      = 320;
  localparam int HOME_Y      = 440;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int OBJ_SIZE    = 16;
  localparam int FIXED_SHIFT = 6;
  localparam int BASE_V      = 128;
  localparam int STEP_V      = 64;
  localparam int VX0         = 48;
  localparam int MAX_V       = 512;
  localparam int GRAVITY     = 4;
  localparam int LOST_FRAMES = 30;
  localparam int MAX_LEVEL   = 4;
  localparam int POS_W       = 22;
  localparam int V_W         = 12;
  localparam int CNT_W       = 5;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_FLY    = 2'd2;
  localparam logic [1:0] S_LOST   = 2'd3;
  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic signed [V_W-1:0] vel_t;
  localparam pos_t HOME_X_FP = pos_t'(HOME_X << FIXED_SHIFT);
  localparam pos_t HOME_Y_FP = pos_t'(HOME_Y << FIXED_SHIFT);
  localparam pos_t X_MAX_PX  = pos_t'(SCREEN_W - OBJ_SIZE);
  localparam pos_t X_MAX_FP  = pos_t'((SCREEN_W - OBJ_SIZE) << FIXED_SHIFT);
  localparam pos_t Y_EXIT_PX = pos_t'(SCREEN_H);
  localparam vel_t V_LIM     = vel_t'(MAX_V);

  function automatic logic [2:0] sat_level(input logic [2:0] l);
    return (l > 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : l;
  endfunction

  function automatic vel_t clamp_v(input vel_t v);
    return (v > V_LIM) ? V_LIM : (v < -V_LIM) ? -V_LIM : v;
  endfunction

  function automatic vel_t abs_v(input vel_t v);
    return v[V_W-1] ? -v : v;
  endfunction
endpackage

// File: rtl/ball_flight_ctrl_if.sv
// ball_flight_ctrl_if: launch handshake, frame/collision events and ball
// position outputs between the launch FSM side (master) and the controller (slave).
interface ball_flight_ctrl_if;
  logic              startGame;
  logic [2:0]        startSpeed;
  logic              startOfFrame;
  logic              collision_x;
  logic              collision_y;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic              ball_active;
  logic              ball_lost;
  modport master (
    output startGame, startSpeed, startOfFrame, collision_x, collision_y,
    input  topLeftX, topLeftY, ball_active, ball_lost
  );
  modport slave (
    input  startGame, startSpeed, startOfFrame, collision_x, collision_y,
    output topLeftX, topLeftY, ball_active, ball_lost
  );
endinterface

// File: rtl/ball_speed_lut.sv
// ball_speed_lut: maps a launch level to the initial fixed-point velocity,
// saturating levels above MAX_LEVEL.
module ball_speed_lut
  import ball_pkg::*;
(
  input  logic [2:0] lvl_i,
  output vel_t       vx0_o,
  output vel_t       vy0_o
);
  logic [2:0] lvl;
  assign lvl   = sat_level(lvl_i);
  assign vx0_o = vel_t'(VX0);
  assign vy0_o = vel_t'(-(BASE_V + STEP_V * int'(lvl)));
endmodule

// File: rtl/ball_flight_ctrl.sv
// ball_flight_ctrl: launches the ball from the cannon, moves it once per frame with
// wall/collision reflection and reports bottom-edge loss. BALL_GRAVITY_EN adds gravity.
module ball_flight_ctrl
  import ball_pkg::*;
(
  input logic               clk,
  input logic               resetN,
  ball_flight_ctrl_if.slave bus
);
  logic [1:0]       state_q, state_d;
  logic [2:0]       lvl_q, lvl_d;
  pos_t             px_q, px_d, py_q, py_d;
  vel_t             vx_q, vx_d, vy_q, vy_d;
  logic             fx_q, fx_d, fy_q, fy_d;
  logic             lost_q, lost_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  vel_t             vx0, vy0, vx_r, vy_r, vy_g, vx_c, vy_c, vx_w, vy_w;
  pos_t             px_s, py_s, px_w, py_w;
  logic             hit_l, hit_r, hit_t, hit_b;

  ball_speed_lut u_lut (.lvl_i(lvl_q), .vx0_o(vx0), .vy0_o(vy0));

  // A collision pulse in the frame cycle itself counts as well as a sticky flag.
  assign vx_r = (fx_q | bus.collision_x) ? -vx_q : vx_q;
  assign vy_r = (fy_q | bus.collision_y) ? -vy_q : vy_q;
`ifdef BALL_GRAVITY_EN
  assign vy_g = vy_r + vel_t'(GRAVITY);
`else
  assign vy_g = vy_r;
`endif
  assign vx_c = clamp_v(vx_r);
  assign vy_c = clamp_v(vy_g);
  assign px_s = px_q + pos_t'(vx_c);
  assign py_s = py_q + pos_t'(vy_c);
  // Walls override the collision-derived direction for this frame.
  assign hit_l = px_s[POS_W-1];
  assign hit_r = (px_s >>> FIXED_SHIFT) > X_MAX_PX;
  assign hit_t = py_s[POS_W-1];
  assign px_w  = hit_l ? '0 : hit_r ? X_MAX_FP : px_s;
  assign vx_w  = hit_l ? abs_v(vx_c) : hit_r ? -abs_v(vx_c) : vx_c;
  assign py_w  = hit_t ? '0 : py_s;
  assign vy_w  = hit_t ? abs_v(vy_c) : vy_c;
  assign hit_b = (py_w >>> FIXED_SHIFT) >= Y_EXIT_PX;

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    px_d    = px_q;
    py_d    = py_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    lost_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        px_d = HOME_X_FP;
        py_d = HOME_Y_FP;
        if (bus.startGame) begin
          state_d = S_LAUNCH;
          lvl_d   = sat_level(bus.startSpeed);
        end
      end
      S_LAUNCH: begin
        vx_d    = vx0;
        vy_d    = vy0;
        fx_d    = 1'b0;
        fy_d    = 1'b0;
        state_d = S_FLY;
      end
      S_FLY: begin
        fx_d = fx_q | bus.collision_x;
        fy_d = fy_q | bus.collision_y;
        if (bus.startOfFrame) begin
          px_d = px_w;
          py_d = py_w;
          vx_d = vx_w;
          vy_d = vy_w;
          fx_d = 1'b0;
          fy_d = 1'b0;
          if (hit_b) begin
            state_d = S_LOST;
            lost_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        if (bus.startOfFrame) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(LOST_FRAMES - 1)) begin
            state_d = S_IDLE;
            px_d    = HOME_X_FP;
            py_d    = HOME_Y_FP;
            vx_d    = '0;
            vy_d    = '0;
            cnt_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      lvl_q   <= '0;
      px_q    <= HOME_X_FP;
      py_q    <= HOME_Y_FP;
      vx_q    <= '0;
      vy_q    <= '0;
      fx_q    <= 1'b0;
      fy_q    <= 1'b0;
      lost_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      px_q    <= px_d;
      py_q    <= py_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      lost_q  <= lost_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.topLeftX    = 11'(px_q >>> FIXED_SHIFT);
  assign bus.topLeftY    = 11'(py_q >>> FIXED_SHIFT);
  assign bus.ball_active = (state_q == S_FLY);
  assign bus.ball_lost   = lost_q;
endmodule

// File: tb/tb_ball_flight_ctrl.sv
// tb_ball_flight_ctrl: scoreboard bench for ball_flight_ctrl; a frame-level model
// queues the expected position per frame and the DUT result is popped and compared.
module tb_ball_flight_ctrl;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  ball_flight_ctrl_if bus();
  ball_flight_ctrl dut (.clk(clk), .resetN(resetN), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {int x; int y; bit act; bit lost;} exp_t;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int mx, my, mvx, mvy, mcnt;
  bit mfx, mfy, mfly, mlost;
  bit m_hitl, m_hitr, m_lost, m_seen_r;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampi(input int v);
    return (v > 512) ? 512 : (v < -512) ? -512 : v;
  endfunction

  task automatic m_home();
    mx = 320 * 64; my = 440 * 64; mvx = 0; mvy = 0;
    mfx = 0; mfy = 0; mfly = 0; mlost = 0; mcnt = 0;
  endtask

  task automatic do_reset();
    bus.startGame = 0; bus.startSpeed = 0; bus.startOfFrame = 0;
    bus.collision_x = 0; bus.collision_y = 0;
    @(negedge clk); resetN = 0;
    @(negedge clk); resetN = 1;
    m_home(); m_seen_r = 0;
    @(negedge clk);
    check("rst_x", bus.topLeftX, 320);
    check("rst_y", bus.topLeftY, 440);
    check("rst_active", bus.ball_active, 0);
    check("rst_lost", bus.ball_lost, 0);
  endtask

  task automatic launch(input int lvl);
    @(negedge clk); bus.startGame = 1; bus.startSpeed = 3'(lvl);
    @(negedge clk); bus.startGame = 0;
    @(negedge clk);
    check("launch_active", bus.ball_active, 1);
    mvx = 48; mvy = -(128 + 64 * ((lvl > 4) ? 4 : lvl)); mfly = 1;
  endtask

  task automatic pulse_cx();
    @(negedge clk); bus.collision_x = 1;
    @(negedge clk); bus.collision_x = 0;
    if (mfly) mfx = 1;
  endtask

  task automatic frame(input bit cx, input bit cy);
    exp_t e, g;
    int vx, vy, nx, ny;
    @(negedge clk);
    bus.startOfFrame = 1; bus.collision_x = cx; bus.collision_y = cy;
    m_hitl = 0; m_hitr = 0; e.lost = 0;
    if (mfly) begin
      vx = (mfx | cx) ? -mvx : mvx;
      vy = (mfy | cy) ? -mvy : mvy;
`ifdef BALL_GRAVITY_EN
      vy = vy + 4;
`endif
      vx = clampi(vx); vy = clampi(vy);
      nx = mx + vx; ny = my + vy;
      if (nx < 0) begin nx = 0; vx = absi(vx); m_hitl = 1; end
      else if ((nx >>> 6) > 624) begin nx = 624 * 64; vx = -absi(vx); m_hitr = 1; m_seen_r = 1; end
      if (ny < 0) begin ny = 0; vy = absi(vy); end
      mx = nx; my = ny; mvx = vx; mvy = vy; mfx = 0; mfy = 0;
      if ((ny >>> 6) >= 480) begin e.lost = 1; mfly = 0; mlost = 1; mcnt = 0; end
    end else if (mlost) begin
      mcnt++;
      if (mcnt == 30) m_home();
    end
    e.x = mx >>> 6; e.y = my >>> 6; e.act = mfly;
    m_lost = e.lost;
    sb.push_back(e);
    @(negedge clk);
    bus.startOfFrame = 0; bus.collision_x = 0; bus.collision_y = 0;
    g = sb.pop_front();
    check("frame_x", bus.topLeftX, g.x);
    check("frame_y", bus.topLeftY, g.y);
    check("frame_active", bus.ball_active, g.act);
    check("frame_lost", bus.ball_lost, g.lost);
    if (g.lost) begin
      @(negedge clk);
      check("lost_pulse_end", bus.ball_lost, 0);
    end
  endtask

  bit done;
  bit cy;

  initial begin
    do_reset();
    frame(0, 0);
    check("idle_no_motion_y", bus.topLeftY, 440);

    launch(0);
    repeat (3) frame(0, 0);
    check("t1_y", bus.topLeftY, 434);
    check("t1_x", bus.topLeftX, 322);
    @(negedge clk); bus.startGame = 1; bus.startSpeed = 7;
    @(negedge clk); bus.startGame = 0;
    frame(0, 0);
    check("startgame_ignored_y", bus.topLeftY, 432);
    pulse_cx();
    frame(0, 1);
    check("both_reflect_y", bus.topLeftY, 434);
    check("both_reflect_x", bus.topLeftX, 322);

    do_reset(); launch(4); frame(0, 0);
    check("lvl4_y", bus.topLeftY, 434);
    do_reset(); launch(7); frame(0, 0);
    check("lvl7_y", bus.topLeftY, 434);
    frame(0, 0);

    @(negedge clk); #2 resetN = 0;
    #1;
    check("async_rst_x", bus.topLeftX, 320);
    check("async_rst_y", bus.topLeftY, 440);
    check("async_rst_active", bus.ball_active, 0);
    m_home();
    @(negedge clk); resetN = 1;

    do_reset(); launch(0);
    frame(1, 0);
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      cy = mfly && (mvy > 0) && ((my >>> 6) > 300) && !m_seen_r;
      frame(0, cy);
      if (m_hitl) check("left_clamp_x", bus.topLeftX, 0);
      if (m_hitr) check("right_clamp_x", bus.topLeftX, 624);
      if (m_lost) done = 1;
    end
    check("lost_reached", int'(done), 1);
    repeat (30) frame(0, 0);
    check("home_x", bus.topLeftX, 320);
    check("home_y", bus.topLeftY, 440);
    check("home_active", bus.ball_active, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
